// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory behind a fixed-latency request/response controller.
// busy stalls the core's MEM stage while a read or write is in flight.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_done,
    output logic        busy,
    output logic        misaligned_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic          rd_valid_d, wr_done_d, mis_d, commit;
    logic [31:0]   mem [DEPTH_WORDS];

    // Address bits above the array size are deliberately ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:AW+2], wr_addr[31:AW+2]};

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        mis_d      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                // Write wins over a simultaneous read; the read stays pending at the core.
                if (wr_en) begin
                    if (wr_addr[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = WRITE_WAIT;
                        cnt_d   = 4'(WRITE_LATENCY - 1);
                        idx_d   = wr_addr[AW+1:2];
                        data_d  = wr_data;
                    end
                end else if (rd_en) begin
                    if (rd_addr[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = 4'(READ_LATENCY - 1);
                        idx_d   = rd_addr[AW+1:2];
                    end
                end
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WRITE_WAIT: begin
                if (cnt == '0) begin
                    state_d   = IDLE;
                    wr_done_d = 1'b1;
                    commit    = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            idx_q          <= '0;
            data_q         <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            wr_done        <= 1'b0;
            busy           <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            rd_valid       <= rd_valid_d;
            wr_done        <= wr_done_d;
            busy           <= (state_d != IDLE);
            misaligned_err <= mis_d;
            if (rd_valid_d) begin
                rd_data <= mem[idx_q];
            end
        end
    end

    // Array has no reset; an aborted write never reaches here because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed table, hand sequences,
// randomized traffic against a transaction-level reference model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int RL    = 2;
    localparam int WL    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rd_en, wr_en, rd_valid, wr_done, busy, misaligned_err;
    logic [31:0] rd_addr, wr_addr, wr_data, rd_data;

    logic        reset2, rd_en2, wr_en2, rd_valid2, wr_done2, busy2, misaligned_err2;
    logic [31:0] rd_addr2, wr_addr2, wr_data2, rd_data2;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .busy(busy), .misaligned_err(misaligned_err)
    );

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2), .WRITE_LATENCY(3)) dut2 (
        .clk(clk), .reset(reset2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .wr_done(wr_done2), .busy(busy2), .misaligned_err(misaligned_err2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a pending transaction completes a fixed number of edges after it is taken.
    bit [31:0]   mem_m [DEPTH];
    bit          m_pend, m_is_wr, m_busy, m_rv, m_wd, m_me, took_wr, took_rd;
    bit [31:0]   m_rd, m_data;
    int          m_idx, m_done_at;
    int          edge_n = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 0; m_busy = 0; m_rv = 0; m_wd = 0; m_me = 0; m_rd = 0;
            took_wr = 0; took_rd = 0;
        end else begin
            edge_n++;
            m_rv = 0; m_wd = 0; m_me = 0; took_wr = 0; took_rd = 0;
            if (m_pend) begin
                if (edge_n == m_done_at) begin
                    m_pend = 0;
                    if (m_is_wr) begin
                        mem_m[m_idx] = m_data;
                        m_wd = 1;
                    end else begin
                        m_rd = mem_m[m_idx];
                        m_rv = 1;
                    end
                end
            end else if (wr_en) begin
                took_wr = 1;
                if (wr_addr % 4 != 0) m_me = 1;
                else begin
                    m_pend = 1; m_is_wr = 1; m_data = wr_data;
                    m_idx = int'((wr_addr / 4) % DEPTH);
                    m_done_at = edge_n + WL;
                end
            end else if (rd_en) begin
                took_rd = 1;
                if (rd_addr % 4 != 0) m_me = 1;
                else begin
                    m_pend = 1; m_is_wr = 0;
                    m_idx = int'((rd_addr / 4) % DEPTH);
                    m_done_at = edge_n + RL;
                end
            end
            m_busy = m_pend;
        end
    end

    bit mon_on = 0;
    int n_rv, n_wd, n_me, rv_edge, wd_edge;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("cycle", {28'd0, busy, rd_valid, wr_done, misaligned_err, rd_data},
                {28'd0, m_busy, m_rv, m_wd, m_me, m_rd});
            if (rd_valid === 1'b1) begin n_rv++; rv_edge = edge_n; end
            if (wr_done === 1'b1) begin n_wd++; wd_edge = edge_n; end
            if (misaligned_err === 1'b1) n_me++;
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 40 && m_pend; k++) begin
            @(posedge clk); #1;
        end
        chk("idle_timeout", {63'd0, m_pend}, 64'd0);
        @(negedge clk); #1;
    endtask

    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit taken = 0;
        n_rv = 0; n_wd = 0; n_me = 0;
        if (wr) begin wr_en = 1; wr_addr = a; wr_data = d; end
        else begin rd_en = 1; rd_addr = a; end
        for (int k = 0; k < 20 && !taken; k++) begin
            @(posedge clk); #1;
            taken = wr ? took_wr : took_rd;
        end
        wr_en = 0; rd_en = 0;
        chk("accept_timeout", {63'd0, taken}, 64'd1);
        wait_idle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom();
        r[AW+1:2] = AW'($urandom_range(15));
        r[1:0] = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
        return r;
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_rv;
        int          exp_wd;
        int          exp_me;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[12];
    int   lat;
    int   seen_wd, seen_rv, seen_busy;
    int   init_idx[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 32'h0000_0000, 32'h0,          1, 0, 0, 32'h0000_0000};
        tbl[1]  = '{1, 32'h0000_0010, 32'hDEAD_BEEF,  0, 1, 0, 32'h0000_0000};
        tbl[2]  = '{0, 32'h0000_0010, 32'h0,          1, 0, 0, 32'hDEAD_BEEF};
        tbl[3]  = '{0, 32'h0000_0006, 32'h0,          0, 0, 1, 32'hDEAD_BEEF};
        tbl[4]  = '{1, 32'h0000_1008, 32'hA5A5_A5A5,  0, 1, 0, 32'hDEAD_BEEF};
        tbl[5]  = '{0, 32'h0000_0008, 32'h0,          1, 0, 0, 32'hA5A5_A5A5};
        tbl[6]  = '{1, 32'h0000_0003, 32'h1111_1111,  0, 0, 1, 32'hA5A5_A5A5};
        tbl[7]  = '{0, 32'h0000_0000, 32'h0,          1, 0, 0, 32'h0000_0000};
        tbl[8]  = '{0, 32'h0000_0010, 32'h0,          1, 0, 0, 32'hDEAD_BEEF};
        tbl[9]  = '{0, 32'hFFFF_FFFC, 32'h0,          1, 0, 0, 32'h0000_0000};
        tbl[10] = '{1, 32'h7FFF_F03C, 32'hCAFE_F00D,  0, 1, 0, 32'h0000_0000};
        tbl[11] = '{0, 32'h0000_003C, 32'h0,          1, 0, 0, 32'hCAFE_F00D};

        reset = 1; rd_en = 0; wr_en = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
        reset2 = 0; rd_en2 = 0; wr_en2 = 0; rd_addr2 = 0; wr_addr2 = 0; wr_data2 = 0;
        #1 reset = 0;
        #8;
        chk("reset_state", {28'd0, busy, rd_valid, wr_done, misaligned_err, rd_data}, 64'd0);
        @(posedge clk); #3 reset = 1; mon_on = 1;

        // Give every word the bench touches a known value.
        for (int i = 0; i < 16; i++) init_idx[i] = i;
        init_idx[16] = DEPTH - 1;
        for (int i = 0; i < 17; i++) txn(1, 32'(init_idx[i] * 4), 32'h0);

        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].wr, tbl[i].addr, tbl[i].data);
            chk($sformatf("vec%0d_rv", i), 64'(n_rv), 64'(tbl[i].exp_rv));
            chk($sformatf("vec%0d_wd", i), 64'(n_wd), 64'(tbl[i].exp_wd));
            chk($sformatf("vec%0d_me", i), 64'(n_me), 64'(tbl[i].exp_me));
            chk($sformatf("vec%0d_rd", i), {32'd0, rd_data}, {32'd0, tbl[i].exp_rd});
        end

        // Simultaneous read and write to the same word: write first, read right after.
        n_rv = 0; n_wd = 0; n_me = 0;
        wr_en = 1; wr_addr = 32'h20; wr_data = 32'h1234_5678;
        rd_en = 1; rd_addr = 32'h20;
        for (int k = 0; k < 30 && (wr_en || rd_en); k++) begin
            @(posedge clk); #1;
            if (took_wr) wr_en = 0;
            if (took_rd) rd_en = 0;
        end
        chk("both_accept_timeout", {62'd0, wr_en, rd_en}, 64'd0);
        wr_en = 0; rd_en = 0;
        wait_idle();
        chk("both_wd", 64'(n_wd), 64'd1);
        chk("both_rv", 64'(n_rv), 64'd1);
        chk("both_rd", {32'd0, rd_data}, 64'h1234_5678);
        chk("both_gap", 64'(rv_edge - wd_edge), 64'(1 + RL));

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            wr_en   = ($urandom_range(3) == 0);
            rd_en   = ($urandom_range(2) == 0);
            wr_addr = rand_addr();
            rd_addr = rand_addr();
            wr_data = $urandom();
            if ($urandom_range(79) == 0) begin
                #2 reset = 0;
                @(posedge clk); #3 reset = 1;
            end
        end
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
        wait_idle();
        mon_on = 0;

        // Second instance (write latency 3): reset aborts an in-flight write.
        @(posedge clk); #1 reset2 = 1;
        wr_en2 = 1; wr_addr2 = 32'h30; wr_data2 = 32'h0;
        @(posedge clk); #1 wr_en2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_done2 === 1'b1) break;
        end
        chk("pre_wr_done2", {63'd0, wr_done2}, 64'd1);
        wr_en2 = 1; wr_addr2 = 32'h30; wr_data2 = 32'hFFFF_FFFF;
        @(posedge clk); #1 wr_en2 = 0;
        chk("busy2_after_accept", {63'd0, busy2}, 64'd1);
        @(posedge clk); #2 reset2 = 0;
        #1 chk("reset2_outputs", {28'd0, busy2, rd_valid2, wr_done2, misaligned_err2, rd_data2}, 64'd0);
        @(negedge clk);
        chk("reset2_outputs_held", {28'd0, busy2, rd_valid2, wr_done2, misaligned_err2, rd_data2}, 64'd0);
        @(posedge clk); #3 reset2 = 1;
        seen_wd = 0; seen_rv = 0; seen_busy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wr_done2 !== 1'b0) seen_wd++;
            if (rd_valid2 !== 1'b0) seen_rv++;
            if (busy2 !== 1'b0) seen_busy++;
        end
        chk("abort_no_wr_done", 64'(seen_wd), 64'd0);
        chk("abort_no_rd_valid", 64'(seen_rv), 64'd0);
        chk("abort_idle", 64'(seen_busy), 64'd0);
        rd_en2 = 1; rd_addr2 = 32'h30;
        @(posedge clk); #1 rd_en2 = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rd_valid2 === 1'b1) begin lat = k; break; end
        end
        chk("abort_read_latency", 64'(lat), 64'd2);
        chk("abort_read_data", {32'd0, rd_data2}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Word-addressed data memory with a fixed-latency request/response controller.
- Sits directly downstream of the pipelined CPU core's data-memory port: it consumes the CPU's read and write requests and returns read data to the MEM/WB stage.
- Provides a busy indication that the core uses as a pipeline stall.
- Configurable wait states, so the core's stall logic is exercised with realistic memory latency.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two; AW = log2(DEPTH_WORDS).
- READ_LATENCY, 2: cycles from read acceptance edge to rd_valid; legal range 1..15.
- WRITE_LATENCY, 1: cycles from write acceptance edge to commit/wr_done; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_en  input  1  read request; held by the core until accepted.
- rd_addr  input  32  byte address of the read.
- rd_data  output  32  read data; valid when rd_valid=1; holds its value otherwise.
- rd_valid  output  1  one-cycle pulse marking read completion.
- wr_en  input  1  write request; held by the core until accepted.
- wr_addr  input  32  byte address of the write.
- wr_data  input  32  write data.
- wr_done  output  1  one-cycle pulse marking write commit.
- busy  output  1  controller not in IDLE; the core stalls its MEM stage while busy=1.
- misaligned_err  output  1  one-cycle pulse; request rejected because addr[1:0]!=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; counter=0.
  - rd_data=0, rd_valid=0, wr_done=0, busy=0, misaligned_err=0.
  - Memory array is not cleared.
- Reset asserted mid-operation: the pending request is aborted.
  - A write in WRITE_WAIT is not committed.
  - No rd_valid or wr_done is issued after reset releases.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT. busy is registered and equals (state != IDLE).
- Acceptance: on a rising edge with state==IDLE.
  - Latch address, and data for writes.
  - Load counter with LATENCY-1 and enter the wait state.
- Priority: if rd_en and wr_en are both 1 in IDLE, the write is accepted. The read is ignored and must be held by the core.
- Misaligned request (selected address bits [1:0] != 0 in IDLE):
  - No state change and no memory access.
  - misaligned_err=1 for exactly the next cycle.
  - The request is consumed; the core must drop or correct it.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- READ_WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0: rd_data <= mem[index], rd_valid=1 for one cycle, state -> IDLE.
  - rd_valid therefore rises exactly READ_LATENCY edges after the acceptance edge.
- WRITE_WAIT:
  - Same counting.
  - On the edge where counter==0: mem[index] <= latched data, wr_done=1 for one cycle, state -> IDLE.
- Back-to-back: busy is 0 in the rd_valid/wr_done cycle, so a new request can be accepted on the next edge. No dead cycle beyond that.
- Request inputs (en, addr, data) are ignored while busy=1. Changes to them do not affect the in-flight operation.
- Read-after-write to the same address, accepted after wr_done, returns the new data.
- rd_data holds its last completed value until the next read completes.
- Writes do not alter rd_data.

Test Plan:
- Reset, then read addr 0x0 with READ_LATENCY=2 -> busy=1 for 2 cycles; rd_valid pulses exactly 2 edges after acceptance; rd_data=0x00000000 (preloaded 0).
- Write 0xDEADBEEF to 0x10, then read 0x10 -> wr_done 1 edge after acceptance; read returns 0xDEADBEEF with rd_valid 2 edges after its acceptance.
- Simultaneous rd_en (0x20) and wr_en (0x20, 0x12345678) held in IDLE:
  - Write is accepted first; read is accepted on the edge after wr_done.
  - Read returns 0x12345678.
- Read addr 0x6 -> misaligned_err pulses one cycle; busy stays 0; rd_valid never asserts; memory unchanged.
- Write 0xA5A5A5A5 to addr DEPTH_WORDS*4+0x8 (wrap) -> read of 0x8 returns 0xA5A5A5A5.
- Accept write of 0xFFFFFFFF to 0x30 with WRITE_LATENCY=3; assert reset after 1 cycle; release; read 0x30:
  - No wr_done is seen.
  - Read returns the old value (0x00000000).
  - All outputs were 0 during reset.
